uart_rx_byte: RTL and testbench

//  - UART 8N1 byte receiver; sits directly upstream of the message parser.
//  - Samples the asynchronous serial line on clk_50M and assembles bytes LSB-first.
//  - Presents each good byte on rx_msg with a one-cycle rx_complete strobe;
//    the parser stores bytes until '#' (0x23).
//  - Flags framing errors and never forwards a byte whose stop bit is bad.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx_byte.sv | 158 +++++++++++++++
 tb/tb_uart_rx_byte.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive path: receiver state encoding,
//   default clock / line-rate parameters and the message terminator byte
//   recognised by the downstream parser.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    // '#' closes a message in the parser downstream of the receiver.
    localparam logic [7:0] MSG_TERM = 8'h23;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level. Both flops
//   reset to 1 so an idle-high serial line does not look like a start bit
//   when reset is released.
// Ports
//   clk    in  1  destination clock
//   reset  in  1  synchronous, active-high reset
//   d      in  1  asynchronous input
//   q      out 1  synchronized output
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver. The serial line is synchronized, the start bit
//   is qualified at its mid-point and every following bit is sampled one
//   bit period later, so all samples land mid-bit. Good bytes are shown on
//   rx_msg with a one-cycle rx_complete strobe; a low stop bit gives a
//   one-cycle frame_error strobe and the byte is dropped.
// Ports
//   clk_50M      in  1  system clock
//   reset        in  1  synchronous, active-high reset
//   rx           in  1  asynchronous serial line, idles high
//   rx_msg       out 8  last good byte received (held between strobes)
//   rx_complete  out 1  one-cycle strobe, rx_msg valid in the same cycle
//   frame_error  out 1  one-cycle strobe, stop bit sampled low
//   rx_busy      out 1  high while a frame is being received
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, waiting for rx_s to go low
// START      | half-bit wait, then re-check start bit (filters glitches)
// DATA       | sample 8 data bits LSB first, one bit period apart
// STOP       | sample stop bit; high -> deliver byte, low -> frame error
// WAIT_IDLE  | after a frame error, wait for the line to return high
import uart_pkg::*;

module uart_rx_byte #(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_complete,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);

    logic rx_s;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shreg, shreg_next;
    logic [7:0]       msg_next;
    logic             complete_next, ferr_next, busy_next;

    sync_2ff u_sync (
        .clk   (clk_50M),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_msg      <= '0;
            rx_complete <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            bit_idx     <= bit_idx_next;
            shreg       <= shreg_next;
            rx_msg      <= msg_next;
            rx_complete <= complete_next;
            frame_error <= ferr_next;
            rx_busy     <= busy_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CNT_W'(1);
        bit_idx_next  = bit_idx;
        shreg_next    = shreg;
        msg_next      = rx_msg;
        complete_next = 1'b0;
        ferr_next     = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (cnt == CNT_HALF_END) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            DATA: begin
                // The counter wraps per bit without a state change; only
                // the last bit moves the FSM on.
                if (cnt == CNT_BIT_END) begin
                    cnt_next     = '0;
                    shreg_next   = {rx_s, shreg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                // Leaving at mid-stop-bit lets the next start edge be seen
                // even when frames are sent with no idle gap.
                if (cnt == CNT_BIT_END) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        msg_next      = shreg;
                        complete_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == START) || (state_next == DATA) ||
                    (state_next == STOP);
    end

endmodule : uart_rx_byte

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte
//   Directed bench for uart_rx_byte: single byte with latency, back-to-back
//   message, start glitch, framing error with held-low line, reset in the
//   middle of a frame, and +/-2% sender rate offset.
module tb_uart_rx_byte;

    import uart_pkg::*;

    localparam int CPB  = 434;
    localparam int HALF = 217;
    localparam int LAT  = HALF + 9 * CPB;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       frame_error;
    logic       rx_busy;

    uart_rx_byte dut (
        .clk_50M     (clk_50M),
        .reset       (reset),
        .rx          (rx),
        .rx_msg      (rx_msg),
        .rx_complete (rx_complete),
        .frame_error (frame_error),
        .rx_busy     (rx_busy)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe monitor
    logic [7:0] rx_q[$];
    int   n_done        = 0;
    int   n_ferr        = 0;
    int   n_wide        = 0;
    int   n_both        = 0;
    int   last_done_cyc = -1;
    logic prev_c        = 1'b0;
    logic prev_f        = 1'b0;

    always @(negedge clk_50M) begin
        if (rx_complete) begin
            rx_q.push_back(rx_msg);
            n_done++;
            last_done_cyc = cyc;
        end
        if (frame_error) n_ferr++;
        if ((rx_complete && prev_c) || (frame_error && prev_f)) n_wide++;
        if (rx_complete && frame_error) n_both++;
        prev_c = rx_complete;
        prev_f = frame_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    int fall_cyc;

    // Called at a negedge; returns at a negedge with the line left at the
    // stop-bit level so consecutive calls give gap-free frames.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int bc);
        rx = 1'b0;
        fall_cyc = cyc;
        idle(bc);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(bc);
        end
        rx = stop;
        idle(bc);
    endtask

    function automatic logic [31:0] q_at(input int idx);
        return (idx < rx_q.size()) ? {24'd0, rx_q[idx]} : 32'h100;
    endfunction

    logic [7:0] msg_bytes [7] = '{8'h49, 8'h46, 8'h4D, 8'h2D, 8'h45, 8'h2D, MSG_TERM};
    logic [7:0] rate_bytes[3] = '{8'h00, 8'hFF, 8'hA5};
    int         rates     [2] = '{425, 443};

    initial begin
        int base_d, base_f, qbase, diff;
        logic saw_busy;

        // Reset state
        reset = 1'b1;
        idle(5);
        check("rst_msg", rx_msg, 8'h00);
        check("rst_complete", rx_complete, 1'b0);
        check("rst_ferr", frame_error, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        reset = 1'b0;
        idle(20);

        // 1. single byte 0x23 and its latency
        base_d = n_done; base_f = n_ferr; qbase = rx_q.size();
        last_done_cyc = -1;
        send_byte(8'h23, 1'b1, CPB);
        idle(20);
        check("t1_count", n_done - base_d, 1);
        check("t1_byte", q_at(qbase), 8'h23);
        check("t1_msg", rx_msg, 8'h23);
        check("t1_ferr", n_ferr - base_f, 0);
        diff = last_done_cyc - fall_cyc;
        check("t1_latency_in_range", (diff >= LAT + 2 && diff <= LAT + 3), 1'b1);

        // 2. back-to-back message
        idle(CPB);
        base_d = n_done; base_f = n_ferr; qbase = rx_q.size();
        for (int i = 0; i < 7; i++) send_byte(msg_bytes[i], 1'b1, CPB);
        idle(50);
        check("t2_count", n_done - base_d, 7);
        for (int i = 0; i < 7; i++) check($sformatf("t2_byte%0d", i), q_at(qbase + i), msg_bytes[i]);
        check("t2_ferr", n_ferr - base_f, 0);

        // 3. short low glitch
        idle(CPB);
        base_d = n_done; base_f = n_ferr;
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int k = 1; k <= HALF + 3; k++) begin
            @(negedge clk_50M);
            if (rx_busy) saw_busy = 1'b1;
            if (k == 100) rx = 1'b1;
        end
        check("t3_busy_seen", saw_busy, 1'b1);
        check("t3_busy_cleared", rx_busy, 1'b0);
        idle(500);
        check("t3_no_done", n_done - base_d, 0);
        check("t3_no_ferr", n_ferr - base_f, 0);

        // 4. framing error, held-low line, recovery
        base_d = n_done; base_f = n_ferr;
        send_byte(8'h45, 1'b0, CPB);
        check("t4_ferr_once", n_ferr - base_f, 1);
        check("t4_no_done", n_done - base_d, 0);
        check("t4_msg_kept", rx_msg, 8'h23);
        idle(5000);
        check("t4_break_ferr", n_ferr - base_f, 1);
        check("t4_break_done", n_done - base_d, 0);
        check("t4_break_busy", rx_busy, 1'b0);
        rx = 1'b1;
        idle(2 * CPB);
        qbase = rx_q.size();
        send_byte(8'h50, 1'b1, CPB);
        idle(50);
        check("t4_recover_msg", rx_msg, 8'h50);
        check("t4_recover_byte", q_at(qbase), 8'h50);
        check("t4_recover_done", n_done - base_d, 1);

        // 5. reset in the middle of DATA
        idle(CPB);
        base_d = n_done; base_f = n_ferr;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = ((8'h42 >> i) & 8'h01) != 0;
            idle(CPB);
        end
        rx = 1'b0;
        idle(100);
        check("t5_busy_before", rx_busy, 1'b1);
        reset = 1'b1;
        @(negedge clk_50M);
        check("t5_rst_msg", rx_msg, 8'h00);
        check("t5_rst_complete", rx_complete, 1'b0);
        check("t5_rst_ferr", frame_error, 1'b0);
        check("t5_rst_busy", rx_busy, 1'b0);
        reset = 1'b0;
        rx = 1'b1;
        idle(12 * CPB);
        check("t5_aborted_done", n_done - base_d, 0);
        check("t5_aborted_ferr", n_ferr - base_f, 0);
        qbase = rx_q.size();
        send_byte(8'h39, 1'b1, CPB);
        idle(50);
        check("t5_next_msg", rx_msg, 8'h39);
        check("t5_next_byte", q_at(qbase), 8'h39);

        // 6. sender rate +2% / -2%
        for (int r = 0; r < 2; r++) begin
            idle(CPB);
            base_d = n_done; base_f = n_ferr; qbase = rx_q.size();
            for (int i = 0; i < 3; i++) send_byte(rate_bytes[i], 1'b1, rates[r]);
            idle(50);
            check($sformatf("t6_count_bc%0d", rates[r]), n_done - base_d, 3);
            check($sformatf("t6_ferr_bc%0d", rates[r]), n_ferr - base_f, 0);
            for (int i = 0; i < 3; i++)
                check($sformatf("t6_byte%0d_bc%0d", i, rates[r]), q_at(qbase + i), rate_bytes[i]);
        end

        // Strobe shape over the whole run
        check("strobe_width", n_wide, 0);
        check("strobe_exclusive", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_byte
